// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- iterative radix-2 restoring divider for the execute stage.
// Implements DIV / DIVU / REM / REMU. One quotient bit is produced per cycle,
// so a normal divide occupies the unit for WIDTH cycles after the request.
// Divide-by-zero and signed overflow are resolved in the request cycle.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset      in   synchronous active-high reset, aborts any operation
//   start      in   divide request (held while the instruction sits in EX)
//   is_signed  in   1: DIV/REM, 0: DIVU/REMU (sampled with start)
//   want_rem   in   1: remainder, 0: quotient (sampled with start)
//   a, b       in   dividend / divisor (sampled with start)
//   stall      out  freezes upstream pipeline registers (combinational)
//   busy       out  high while iterating
//   done       out  one-cycle pulse, result valid
//   result     out  quotient or remainder, held until replaced or reset
// -----------------------------------------------------------------------------
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic             want_rem,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   quo_q;      // dividend magnitude shifting out, quotient shifting in
   logic [WIDTH-1:0]   rem_q;      // partial remainder
   logic [WIDTH-1:0]   dvs_q;      // divisor magnitude
   logic               neg_quo_q;
   logic               neg_rem_q;
   logic               want_rem_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   result_q;

   // Two's-complement negate when neg is set (used for magnitudes and final sign fix-up)
   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   // Request decode
   logic             a_neg, b_neg, div_zero, sgn_ovf;
   logic [WIDTH-1:0] special_res;

   always_comb begin
      a_neg    = is_signed & a[WIDTH-1];
      b_neg    = is_signed & b[WIDTH-1];
      div_zero = (b == '0);
      sgn_ovf  = is_signed & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (&b);
      if (div_zero)
         special_res = want_rem ? a : '1;
      else
         special_res = want_rem ? '0 : a;
   end

   // One restoring step: shift in the next dividend bit, subtract if it fits
   logic [WIDTH:0]   rem_w, diff_w;
   logic [WIDTH-1:0] rem_d, quo_d, fin_d;

   always_comb begin
      rem_w  = {rem_q, quo_q[WIDTH-1]};
      diff_w = rem_w - {1'b0, dvs_q};
      rem_d  = diff_w[WIDTH] ? rem_w[WIDTH-1:0] : diff_w[WIDTH-1:0];
      quo_d  = {quo_q[WIDTH-2:0], ~diff_w[WIDTH]};
      fin_d  = want_rem_q ? cond_neg(rem_d, neg_rem_q) : cond_neg(quo_d, neg_quo_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  want_rem_q <= want_rem;
                  neg_quo_q  <= a_neg ^ b_neg;
                  neg_rem_q  <= a_neg;
                  if (div_zero || sgn_ovf) begin
                     result_q <= special_res;
                     done_q   <= 1'b1;
                     state_q  <= S_DONE;
                  end else begin
                     quo_q   <= cond_neg(a, a_neg);
                     dvs_q   <= cond_neg(b, b_neg);
                     rem_q   <= '0;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               quo_q <= quo_d;
               rem_q <= rem_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH-1)) begin
                  result_q <= fin_d;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= S_DONE;
               end
            end
            S_DONE: begin
               // start is still asserted by the same instruction here; ignore it
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign stall  = ((state_q == S_IDLE) && start) || (state_q == S_RUN);
   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

   logic        clk = 1'b0;
   logic        reset, start, is_signed, want_rem;
   logic [31:0] a, b;
   logic        stall, busy, done;
   logic [31:0] result;

   int n_chk  = 0;
   int n_fail = 0;

   div_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
      .want_rem(want_rem), .a(a), .b(b), .stall(stall), .busy(busy),
      .done(done), .result(result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      bit          s;
      bit          r;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: RISC-V divide semantics from plain 64-bit arithmetic
   function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                         input bit ms, input bit mr);
      logic signed [31:0] sa32, sb32;
      longint             x, y, q, m;
      if (mb == 32'd0) return mr ? ma : 32'hFFFF_FFFF;
      sa32 = ma;
      sb32 = mb;
      if (ms) begin
         x = sa32;
         y = sb32;
      end else begin
         x = longint'({32'd0, ma});
         y = longint'({32'd0, mb});
      end
      q = x / y;
      m = x % y;
      return mr ? m[31:0] : q[31:0];
   endfunction

   function automatic int model_lat(input logic [31:0] ma, input logic [31:0] mb, input bit ms);
      if (mb == 32'd0) return 1;
      if (ms && ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Issue one divide; returns result, cycles from the start edge to done,
   // number of stalled cycles before done, whether busy was seen, stall in done cycle.
   task automatic run_div(input logic [31:0] ta, input logic [31:0] tb_, input bit ts,
                          input bit tr, input bit hold,
                          output logic [31:0] res, output int lat, output int stl,
                          output bit bsy, output logic stl_done);
      @(negedge clk);
      a = ta; b = tb_; is_signed = ts; want_rem = tr; start = 1'b1;
      #1;
      stl = stall ? 1 : 0;
      bsy = 1'b0;
      lat = -1;
      res = 32'hx;
      stl_done = 1'bx;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         #1;
         if (!hold) start = 1'b0;
         #1;
         if (busy) bsy = 1'b1;
         if (done) begin
            lat = k;
            res = result;
            stl_done = stall;
            break;
         end
         if (stall) stl++;
      end
   endtask

   // Checks one full operation plus the cycle after done
   task automatic do_check(input string nm, input logic [31:0] ta, input logic [31:0] tb_,
                           input bit ts, input bit tr, input bit hold,
                           input logic [31:0] exp, input int exp_lat);
      logic [31:0] res;
      int          lat, stl;
      bit          bsy;
      logic        sd;
      run_div(ta, tb_, ts, tr, hold, res, lat, stl, bsy, sd);
      chk({nm, " result"}, res, exp);
      chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
      chk({nm, " stall cycles"}, 32'(stl), 32'(exp_lat));
      chk({nm, " busy seen"}, {31'd0, bsy}, {31'd0, exp_lat != 1});
      chk({nm, " stall in done"}, {31'd0, sd}, 32'd0);
      @(posedge clk);
      #2;
      chk({nm, " done pulse end"}, {31'd0, done}, 32'd0);
      chk({nm, " no retrigger"}, {31'd0, busy}, 32'd0);
      chk({nm, " result held"}, result, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [10];
      int          dcount;
      logic [31:0] ra, rb, rexp;
      bit          rs, rr;
      int          mode;

      reset = 1'b1; start = 1'b0; is_signed = 1'b0; want_rem = 1'b0;
      a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset result", result, 32'd0);
      chk("reset stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      tbl[0] = '{32'd100,        32'd7,         1'b0, 1'b0, 32'h0000_000E, 33};
      tbl[1] = '{32'hFFFF_FFF9,  32'd2,         1'b1, 1'b0, 32'hFFFF_FFFD, 33};
      tbl[2] = '{32'hFFFF_FFF9,  32'd2,         1'b1, 1'b1, 32'hFFFF_FFFF, 33};
      tbl[3] = '{32'd5,          32'd0,         1'b0, 1'b0, 32'hFFFF_FFFF, 1};
      tbl[4] = '{32'd5,          32'd0,         1'b0, 1'b1, 32'h0000_0005, 1};
      tbl[5] = '{32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1};
      tbl[6] = '{32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000, 1};
      tbl[7] = '{32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 33};
      tbl[8] = '{32'd100,        32'd7,         1'b0, 1'b1, 32'h0000_0002, 33};
      tbl[9] = '{32'd5,          32'd0,         1'b1, 1'b0, 32'hFFFF_FFFF, 1};

      for (int i = 0; i < 10; i++)
         do_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].r, 1'b0,
                  tbl[i].exp, tbl[i].lat);

      // Reset in RUN cycle 10 discards the operation
      @(negedge clk);
      a = 32'd1000; b = 32'd3; is_signed = 1'b0; want_rem = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("mid-run busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("post-reset busy", {31'd0, busy}, 32'd0);
      chk("post-reset done", {31'd0, done}, 32'd0);
      chk("post-reset result", result, 32'd0);
      chk("post-reset stall", {31'd0, stall}, 32'd0);
      dcount = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (done) dcount++;
      end
      chk("post-reset done pulses", 32'(dcount), 32'd0);
      do_check("after reset", 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 32'd14, 33);

      // start held through DONE, then back-to-back second divide
      do_check("held first", 32'd100, 32'd7, 1'b0, 1'b0, 1'b1, 32'd14, 33);
      do_check("back-to-back", 32'hDEAD_BEEF, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0DEA_DBEE, 33);

      // Randomized operands against the reference model
      for (int i = 0; i < 40; i++) begin
         mode = $urandom_range(0, 9);
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         rs = 1'($urandom_range(0, 1));
         rr = 1'($urandom_range(0, 1));
         if (mode == 0) rb = 32'd0;
         if (mode == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
         if (mode == 2) ra = $urandom_range(0, 20);
         rexp = model(ra, rb, rs, rr);
         do_check($sformatf("rand%0d", i), ra, rb, rs, rr, 1'b0, rexp, model_lat(ra, rb, rs));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 integer divider for the pipeline's execute stage, implementing RISC-V DIV/DIVU/REM/REMU semantics. While a division is in flight, it raises `stall`, which the hazard logic uses to drop the enables of the upstream `flopenr` pipeline registers (PC, IF/ID, ID/EX). The result is presented with a one-cycle `done` pulse, in the same cycle `stall` releases. The EX/MEM register then captures the result on the next rising edge.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request from the EX-stage decode; held high while the divide instruction sits in EX.
- `is_signed`  in  1  1 selects DIV/REM; 0 selects DIVU/REMU. Sampled with `start`.
- `want_rem`  in  1  1 returns the remainder; 0 returns the quotient. Sampled with `start`.
- `a`  in  WIDTH  dividend, sampled with `start`.
- `b`  in  WIDTH  divisor, sampled with `start`.
- `stall`  out  1  freezes the upstream pipeline registers (combinational).
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  WIDTH  quotient or remainder; held until the next accepted `start` or `reset`.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: iterating.
  - DONE: result presented.
- IDLE, `start`=1:
  - Latch `is_signed`, `want_rem`, `a`, `b`.
  - Normal case: go to RUN with the iteration counter at 0.
  - Special case: go directly to DONE with the result computed immediately.
- RUN: one restoring shift/subtract step per cycle on the operand magnitudes. After WIDTH steps, go to DONE.
- DONE:
  - `done`=1 for exactly one cycle, then go to IDLE unconditionally.
  - `start` is ignored in DONE because the same instruction is still in EX; this prevents a retrigger.
- Signed operation:
  - Divide |a| by |b|.
  - Negate the quotient when sign(a)≠sign(b).
  - The remainder takes the sign of `a`.
  - All arithmetic is WIDTH bits, two's complement; the quotient truncates toward zero.
- Special cases, decided at `start`, no iteration:
  - Divide by zero (`b`=0): quotient = all ones; remainder = `a`.
  - Signed overflow (`a`=most-negative, `b`=all ones, `is_signed`=1): quotient = `a`; remainder = 0.
- `stall` = (IDLE & `start`) | RUN. It is low in DONE, so the pipeline advances at the end of the DONE cycle.
- `reset` at any time, including mid-RUN:
  - Next state IDLE; the in-flight operation is discarded.
  - `done`=0, `busy`=0, `result`=0, counter=0.

## Timing
- Reset values:
  - `stall`=0 unless `start`=1 (it is combinational).
  - `busy`=0, `done`=0, `result`=0.
- Normal latency: `start` seen at edge E0 → RUN during cycles 1..WIDTH → DONE in cycle WIDTH+1. For WIDTH=32, `done` is high between edges E32 and E33.
- Special-case latency: DONE in the cycle immediately after E0 (`done` high between E0 and E1).
- `result` updates on the edge entering DONE and is stable from then until the next accepted `start`.
- `stall` is high from the `start` cycle through the last RUN cycle: WIDTH+1 cycles in the normal case, 1 cycle in the special case.
- Back-to-back divides: the next instruction's `start` arrives in the cycle after DONE (IDLE) and is accepted normally.
- `start` deasserting mid-RUN (for example on a flush) does not abort the operation. Aborting is done only via `reset`.

## Test plan
- Unsigned quotient:
  - Stimulus: `a`=100, `b`=7, `is_signed`=0, `want_rem`=0.
  - Required: `result`=0x0000000E with `done` pulsing exactly 33 cycles after the `start` edge.
  - Required: `stall` high for 33 consecutive cycles, then low in the `done` cycle.
- Signed quotient and remainder:
  - Stimulus: `a`=0xFFFFFFF9 (−7), `b`=2.
  - Required: quotient 0xFFFFFFFD (−3) and, in a second run, remainder 0xFFFFFFFF (−1).
- Divide by zero:
  - Stimulus: `a`=5, `b`=0.
  - Required: quotient 0xFFFFFFFF and remainder 0x00000005, each with `done` one cycle after `start`.
  - Required: `busy` never high.
- Signed overflow:
  - Stimulus: `a`=0x80000000, `b`=0xFFFFFFFF, `is_signed`=1.
  - Required: quotient 0x80000000 and remainder 0x00000000 in 1 cycle.
  - Cross-check: the same operands with `is_signed`=0 give quotient 0x00000000 after 33 cycles.
- Reset mid-operation:
  - Stimulus: assert `reset` at RUN cycle 10.
  - Required: the next cycle shows IDLE, `result`=0, `busy`=0, and no `done` pulse afterward.
  - Required: a fresh `start` of 100/7 then completes normally with 14.
- Held `start` and back-to-back operation:
  - Stimulus: keep `start` high through DONE; then issue a second divide, 0xDEADBEEF/0x10, in the following cycle.
  - Required: no retrigger in DONE.
  - Required: the second `result`=0x0DEADBEE, and the first `result` stays stable until the second `start` is accepted.
